// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: state register, per-state datapath decode, ECALL halt and retire pulse.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_unit #(
    parameter logic [2:0]  RESET_STATE  = 3'd0,
    parameter logic [31:0] HALT_REG_VAL = 32'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  next_state,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic [31:0] x17_value,
    output logic [2:0]  current_state,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        is_halted,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX_1 = 3'd2, S_EX_2 = 3'd3, S_MEM = 3'd4, S_WB = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_t state;
    state_t legal_next;
    logic   halt_now;
    logic   pw_raw, mr_raw, mw_raw, irw_raw, rw_raw;

    assign current_state = state;
    assign legal_next    = (next_state > 3'd5) ? S_IF : state_t'(next_state);
    assign halt_now      = (state == S_ID) && (opcode == OP_ECALL) && (x17_value == HALT_REG_VAL);

    // A halting ECALL keeps the state in ID so the frozen core still shows where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= state_t'(RESET_STATE);
            is_halted <= 1'b0;
        end else if (!is_halted) begin
            if (halt_now) is_halted <= 1'b1;
            else          state     <= legal_next;
        end
    end

    always_comb begin
        pw_raw     = 1'b0;
        pc_source  = 2'b00;
        i_or_d     = 1'b0;
        mr_raw     = 1'b0;
        mw_raw     = 1'b0;
        irw_raw    = 1'b0;
        mem_to_reg = 2'b00;
        rw_raw     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_IF: begin
                mr_raw  = 1'b1;
                irw_raw = 1'b1;
            end
            S_ID: begin
                if (opcode == OP_ECALL) pw_raw = 1'b1;
            end
            S_EX_1: begin
                case (opcode)
                    OP_R:      begin alu_src_a = 1'b1; alu_src_b = 2'b00; alu_op = 2'b10; end
                    OP_I:      begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b10; end
                    OP_LOAD, OP_STORE, OP_JALR:
                               begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b00; end
                    OP_JAL:    begin alu_src_a = 1'b0; alu_src_b = 2'b10; alu_op = 2'b00; end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b00;
                        alu_op    = 2'b01;
                        pw_raw    = !bcond;
                    end
                    default: ;
                endcase
            end
            S_EX_2: begin
                alu_src_b = 2'b10;
                pw_raw    = 1'b1;
                pc_source = 2'b01;
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) mr_raw = 1'b1;
                if (opcode == OP_STORE) begin
                    mw_raw = 1'b1;
                    pw_raw = 1'b1;
                end
            end
            S_WB: begin
                rw_raw = 1'b1;
                pw_raw = 1'b1;
                if (opcode == OP_LOAD) mem_to_reg = 2'b01;
                if (opcode == OP_JAL || opcode == OP_JALR) begin
                    mem_to_reg = 2'b10;
                    pc_source  = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // Architectural writes are suppressed during reset; fetch enables are left alone so IF looks normal.
    assign pc_write   = pw_raw  && !is_halted && !reset;
    assign mem_write  = mw_raw  && !is_halted && !reset;
    assign reg_write  = rw_raw  && !is_halted && !reset;
    assign mem_read   = mr_raw  && !is_halted;
    assign ir_write   = irw_raw && !is_halted;
    assign instr_done = !is_halted && !reset && (state != S_IF) && (next_state == 3'd0);

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else if (!is_halted) begin
            cycle_count <= cycle_count + 32'd1;
            if (instr_done) instr_count <= instr_count + 32'd1;
        end
    end
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scenario bench for multicycle_control_unit: expected control words are queued as stimulus is driven.
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  next_state = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic        bcond = 1'b0;
    logic [31:0] x17_value = 32'd0;
    logic [2:0]  current_state;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0]  pc_source, mem_to_reg, alu_src_b, alu_op;
    logic        instr_done, is_halted;
    logic [31:0] cycle_count, instr_count;

    localparam logic [6:0] ADD = 7'b0110011, BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, ECALL = 7'b1110011, ADDI = 7'b0010011;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .next_state(next_state), .opcode(opcode), .bcond(bcond),
        .x17_value(x17_value), .current_state(current_state), .pc_write(pc_write),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .is_halted(is_halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pw;
        logic [1:0] ps;
        logic       iod, mr, mw, irw;
        logic [1:0] m2r;
        logic       rw, a;
        logic [1:0] b, op;
        logic       done, h;
    } ctl_t;

    typedef struct {
        logic       r;
        logic [2:0] ns;
        logic [6:0] op;
        logic       bc;
        logic [31:0] x;
        ctl_t       e;
    } stim_t;

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];
    ctl_t got, ex;

    function automatic ctl_t e(input logic [2:0] st, input logic pw, input logic [1:0] ps,
                               input logic iod, input logic mr, input logic mw, input logic irw,
                               input logic [1:0] m2r, input logic rw, input logic a,
                               input logic [1:0] b, input logic [1:0] op, input logic done,
                               input logic h);
        ctl_t c;
        c = '{st, pw, ps, iod, mr, mw, irw, m2r, rw, a, b, op, done, h};
        return c;
    endfunction

    function automatic ctl_t ifo(input logic h);
        return e(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, h);
    endfunction

    function automatic ctl_t zero(input logic [2:0] st, input logic h);
        return e(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h);
    endfunction

    function automatic stim_t s(input logic r, input logic [2:0] ns, input logic [6:0] op,
                                input logic bc, input logic [31:0] x, input ctl_t ec);
        stim_t t;
        t.r = r; t.ns = ns; t.op = op; t.bc = bc; t.x = x; t.e = ec;
        return t;
    endfunction

    function automatic ctl_t sample();
        return '{current_state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, is_halted};
    endfunction

    task automatic drive(input stim_t t);
        @(posedge clk);
        #1;
        reset = t.r; next_state = t.ns; opcode = t.op; bcond = t.bc; x17_value = t.x;
        exp_q.push_back(t.e);
    endtask

    task automatic test_reset();
        stim_t q[$];
        q.push_back(s(1, 1, ADD, 0, 0, ifo(0)));
        q.push_back(s(1, 1, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 1, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 0, ECALL, 0, 0, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            got = sample(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL reset[%0d] got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_add();
        stim_t q[$];
        q.push_back(s(0, 1, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 2, ADD, 0, 0, zero(1, 0)));
        q.push_back(s(0, 5, ADD, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0)));
        q.push_back(s(0, 0, ADD, 0, 0, e(5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)));
        q.push_back(s(0, 1, ADDI, 0, 0, ifo(0)));
        q.push_back(s(0, 2, ADDI, 0, 0, zero(1, 0)));
        q.push_back(s(0, 5, ADDI, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0)));
        q.push_back(s(0, 0, ADDI, 0, 0, e(5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            got = sample(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL add[%0d] got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_branch();
        stim_t q[$];
        q.push_back(s(0, 1, BR, 0, 0, ifo(0)));
        q.push_back(s(0, 2, BR, 0, 0, zero(1, 0)));
        q.push_back(s(0, 0, BR, 0, 0, e(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0)));
        q.push_back(s(0, 1, BR, 1, 0, ifo(0)));
        q.push_back(s(0, 2, BR, 1, 0, zero(1, 0)));
        q.push_back(s(0, 3, BR, 1, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)));
        q.push_back(s(0, 0, BR, 1, 0, e(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            got = sample(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL branch[%0d] got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_mem_jump();
        stim_t q[$];
        q.push_back(s(0, 1, LD, 0, 0, ifo(0)));
        q.push_back(s(0, 2, LD, 0, 0, zero(1, 0)));
        q.push_back(s(0, 4, LD, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)));
        q.push_back(s(0, 5, LD, 0, 0, e(4, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        q.push_back(s(0, 0, LD, 0, 0, e(5, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0)));
        q.push_back(s(0, 1, ST, 0, 0, ifo(0)));
        q.push_back(s(0, 2, ST, 0, 0, zero(1, 0)));
        q.push_back(s(0, 4, ST, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)));
        q.push_back(s(0, 0, ST, 0, 0, e(4, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)));
        q.push_back(s(0, 1, JAL, 0, 0, ifo(0)));
        q.push_back(s(0, 2, JAL, 0, 0, zero(1, 0)));
        q.push_back(s(0, 5, JAL, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0)));
        q.push_back(s(0, 0, JAL, 0, 0, e(5, 1, 2, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0)));
        q.push_back(s(0, 1, JALR, 0, 0, ifo(0)));
        q.push_back(s(0, 2, JALR, 0, 0, zero(1, 0)));
        q.push_back(s(0, 5, JALR, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)));
        q.push_back(s(0, 0, JALR, 0, 0, e(5, 1, 2, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            got = sample(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL mem_jump[%0d] got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_halt();
        stim_t q[$];
        q.push_back(s(0, 1, ECALL, 0, 10, ifo(0)));
        q.push_back(s(0, 0, ECALL, 0, 10, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        for (int k = 0; k < 5; k++) q.push_back(s(0, 2, ECALL, 0, 10, zero(1, 1)));
        q.push_back(s(1, 0, ECALL, 0, 10, zero(1, 1)));
        q.push_back(s(0, 1, ECALL, 0, 9, ifo(0)));
        q.push_back(s(0, 0, ECALL, 0, 9, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        q.push_back(s(0, 0, ECALL, 0, 9, ifo(0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            got = sample(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL halt[%0d] got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_reset_mid_and_illegal();
        stim_t q[$];
        q.push_back(s(0, 1, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 2, ADD, 0, 0, zero(1, 0)));
        q.push_back(s(0, 5, ADD, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0)));
        q.push_back(s(1, 0, ADD, 0, 0, zero(5, 0)));
        q.push_back(s(0, 7, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 6, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 1, ADD, 0, 0, ifo(0)));
        q.push_back(s(0, 0, ADD, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            got = sample(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %h expected %h", i, got, ex);
            end
        end
    endtask

    task automatic test_counters();
        logic [2:0] seq [4];
        logic [31:0] exp_cyc, exp_ins;
        seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd0;
`ifdef CTRL_PERF_CNT_EN
        exp_cyc = 32'd12; exp_ins = 32'd3;
`else
        exp_cyc = 32'd0;  exp_ins = 32'd0;
`endif
        drive(s(1, 1, ADD, 0, 0, ifo(0)));
        for (int n = 0; n < 12; n++) drive(s(0, seq[n % 4], ADD, 0, 0, ifo(0)));
        drive(s(0, 1, ADD, 0, 0, ifo(0)));
        @(negedge clk);
        exp_q.delete();
        checks++;
        if (cycle_count !== exp_cyc) begin
            errors++;
            $display("FAIL cycle_count got %0d expected %0d", cycle_count, exp_cyc);
        end
        checks++;
        if (instr_count !== exp_ins) begin
            errors++;
            $display("FAIL instr_count got %0d expected %0d", instr_count, exp_ins);
        end
        drive(s(1, 0, ADD, 0, 0, ifo(0)));
        drive(s(0, 0, ADD, 0, 0, ifo(0)));
        @(negedge clk);
        exp_q.delete();
        checks++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL counter_clear got %0d/%0d expected 0/0", cycle_count, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_mem_jump();
        test_halt();
        test_reset_mid_and_illegal();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Holds the 3-bit state register of the multicycle RV32I core.
- Each cycle it latches the combinational next-state value produced by the next-state calculator, and decodes current state plus opcode into every datapath enable and mux select.
- Owns ECALL halt detection and the instruction-retire pulse.
- Sits between the next-state logic (upstream) and the datapath: PC, IR, MDR, ALUOut, register file and memory (downstream).

Parameters:
- RESET_STATE, 3'd0 (IF), state loaded on reset.
- HALT_REG_VAL, 32'd10, value of x17 that makes ECALL halt.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high
- next_state  input  3  from the next-state calculator
- opcode  input  7  instruction opcode
- bcond  input  1  ALU branch condition
- x17_value  input  32  register-file read of x17
- current_state  output  3  state register; feeds back to the next-state calculator
- pc_write  output  1  PC load enable
- pc_source  output  2  00 PC+4 (dedicated adder), 01 ALU result, 10 ALUOut
- i_or_d  output  1  0 = memory address is PC, 1 = memory address is ALUOut
- mem_read  output  1  memory read
- mem_write  output  1  memory write
- ir_write  output  1  IR load enable
- mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC+4
- reg_write  output  1  register-file write
- alu_src_a  output  1  0 = PC, 1 = rs1 (A)
- alu_src_b  output  2  00 = rs2 (B), 01 = const 4, 10 = immediate
- alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded
- instr_done  output  1  retire pulse
- is_halted  output  1  sticky halt flag
- cycle_count  output  32  see Optional Feature
- instr_count  output  32  see Optional Feature

Behaviour:
- State encoding: IF=0, ID=1, EX_1=2, EX_2=3, MEM=4, WB=5. Opcode encodings come from the shared opcode header.
- State register: on posedge clk, if reset, current_state <= RESET_STATE and is_halted <= 0. Otherwise, if is_halted, current_state holds its value. Otherwise current_state <= next_state.
- Illegal next_state (6 or 7): the register loads IF instead.
- Outputs are combinational from current_state and opcode (plus bcond where listed). Defaults are all 0; each state below lists only the non-zero outputs.
  - IF: mem_read=1, ir_write=1, i_or_d=0.
  - ID, ECALL: pc_write=1, pc_source=00. All other opcodes: none.
  - EX_1, R-type: a=1, b=00, op=10.
  - EX_1, I-arith: a=1, b=10, op=10.
  - EX_1, LOAD/STORE/JALR: a=1, b=10, op=00.
  - EX_1, JAL: a=0, b=10, op=00.
  - EX_1, branch: a=1, b=00, op=01; pc_write=!bcond, pc_source=00.
  - EX_2: a=0, b=10, op=00, pc_write=1, pc_source=01.
  - MEM: i_or_d=1. LOAD: mem_read=1. STORE: mem_write=1, pc_write=1, pc_source=00.
  - WB: reg_write=1, pc_write=1.
    - mem_to_reg: 01 for LOAD, 10 for JAL/JALR, else 00.
    - pc_source: 10 for JAL/JALR, else 00.
  - Illegal state: all outputs 0.
- instr_done: 1 in any cycle where is_halted=0, reset=0 and current_state != IF and next_state == IF. This includes a not-taken branch in EX_1 and ECALL in ID.
- Halt: in ID with opcode==ECALL and x17_value==HALT_REG_VAL, is_halted <= 1 at the clock edge.
  - In that ID cycle the outputs are the normal ECALL outputs and instr_done=1.
  - From the next cycle, every enable (pc_write, mem_read, mem_write, ir_write, reg_write, instr_done) is forced to 0 until reset.
- Reset mid-instruction: the state returns to IF on the next edge and no write enable is asserted during the reset cycle. Reset has priority over halt.
- Reset values: current_state=0, is_halted=0, counters=0. Combinational outputs take the IF values whenever current_state=IF.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - cycle_count increments by 1 every non-reset, non-halted cycle.
  - instr_count increments on each instr_done.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Undefined: both ports are tied to 32'd0 and no counter registers exist.

Test Plan:
- Reset held 2 cycles, then next_state=ID -> current_state=0 during reset; IF outputs mem_read=1, ir_write=1; current_state=1 one cycle after reset drops.
- ADD sequence IF->ID->EX_1->WB->IF -> EX_1 gives a=1, b=00, op=10; WB gives reg_write=1, mem_to_reg=00, pc_write=1, pc_source=00; instr_done=1 only in WB.
- BEQ in EX_1 with bcond=0 -> pc_write=1, pc_source=00, instr_done=1. With bcond=1 -> pc_write=0; in EX_2, pc_write=1, pc_source=01.
- LOAD through MEM then WB -> MEM gives i_or_d=1, mem_read=1; WB gives mem_to_reg=01. STORE in MEM -> mem_write=1, pc_write=1, instr_done=1.
- ECALL in ID with x17_value=10 -> is_halted=1 next cycle; state frozen at ID; all enables 0 for 5 further cycles. Then reset -> is_halted=0 and state=IF. Repeat with x17_value=9 -> no halt.
- With CTRL_PERF_CNT_EN: run 3 ADDs (12 cycles) -> cycle_count=12, instr_count=3. next_state=7 -> next state IF.
